// File: rtl/display_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Holds the blank pattern and the active-low gfedcba hex font.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    return SEG_TABLE[n];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
// Ports: nibble_i (4-bit hex digit), seg_o (7-bit segment pattern).
module seg7_hex_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous update.
// Ports: clk/rst_n, value/dp_in/load capture, lz_en, enable; seg/dp/an pins, frame_done.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, sh_val_q;
  logic [DIGITS-1:0]     pend_dp_q, sh_dp_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic                  wrap, last, blank, xfer;

  assign wrap  = (cnt_q == CW'(SCAN_DIV - 1));
  assign last  = (idx_q == IW'(DIGITS - 1));
  assign blank = (cnt_q < CW'(BLANK_CYC));

  assign frame_done = enable && wrap && last;
  // Shadow only changes at a frame boundary, or freely while dark.
  assign xfer = frame_done || !enable;

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap)
      idx_d = last ? '0 : idx_q + 1'b1;
  end

  // A digit is suppressed if it and all higher digits are zero; digit 0 never.
  always_comb begin
    logic allz;
    lz_mask = '0;
    allz    = lz_en;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz       = allz && (sh_val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = allz && (i != 0);
    end
  end

  assign nib = sh_val_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble_i (nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    seg_d = lz_mask[idx_q] ? SEG_OFF : dec_seg;
    an_d  = '1;
    if (!blank)
      an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp_in;
      end
      if (xfer) begin
        sh_val_q <= pend_val_q;
        sh_dp_q  <= pend_dp_q;
      end
      if (enable) begin
        cnt_q <= cnt_d;
        idx_q <= idx_d;
        seg_q <= seg_d;
        dp_q  <= ~sh_dp_q[idx_q];
        an_q  <= an_d;
      end else begin
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
        an_q  <= '1;
      end
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
